// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants and types for the FFT input framer: frame
//               geometry, sample width, sample field slices, play states.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Frame geometry and sample width
  localparam int FFT_N     = 256;
  localparam int FFT_LOG2N = 8;
  localparam int FFT_W     = 64;

  // Sample layout: {re, im}, both two's complement
  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  // Play-side sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    WAIT  = 2'd3
  } play_state_e;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ram
// Description : Simple dual-port frame RAM, one synchronous write port and
//               one synchronous read port. Address is {bank, idx}. The read
//               data register has a synchronous clear so the consumer sees 0
//               whenever no frame is being replayed.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ram #(
  parameter int AW = 9,
  parameter int W  = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port: store the accepted sample
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: one-cycle latency, clear has priority over a pending read
  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : fft_frame_ram
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_framer
// Description : Collects stream samples into N-sample frames in a two-bank
//               ping-pong buffer, then starts the FFT core and replays each
//               complete frame one sample per cycle. A bank is only released
//               back to the fill side once the core reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = FFT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         fft_start,
  output logic [W-1:0] fft_x,
  input  logic         fft_done,
  output logic         frame_err,
  output logic         busy
);

  localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE = LOG2N'(1);

  // Fill-side state
  logic             wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0] wr_idx_q,  wr_idx_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             frame_err_q, frame_err_d;

  // Play-side state
  play_state_e      state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_idx_q,  rd_idx_d;

  // Cross-process controls
  logic             xfer;
  logic             bank_release;
  logic             rd_en;
  logic             rd_clr;
  logic [LOG2N-1:0] rd_addr_idx;

  // A bank is writable only while EMPTY; reset masks acceptance entirely
  assign s_ready   = rst & ~bank_full_q[wr_bank_q];
  assign xfer      = s_valid & s_ready;
  assign fft_start = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  // Fill counter, bank flags and framing-error detection
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    frame_err_d = 1'b0;
    if (xfer) begin
      if (wr_idx_q == IDX_MAX) begin
        // Count-based framing wins: commit even without s_last
        bank_full_d[wr_bank_q] = 1'b1;
        wr_idx_d               = '0;
        wr_bank_d              = ~wr_bank_q;
        frame_err_d            = ~s_last;
      end else if (s_last) begin
        // Short frame: drop it and refill the same bank from index 0
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end
    // The play side only ever releases a FULL bank, never the fill bank
    if (bank_release) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
  end

  // Play sequencer: next state, RAM read requests and bank release
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    rd_en        = 1'b0;
    rd_clr       = 1'b0;
    rd_addr_idx  = '0;
    bank_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d = START;
        end
      end
      START: begin
        // Prefetch sample 0 so it appears on fft_x in the first PLAY cycle
        rd_en       = 1'b1;
        rd_addr_idx = '0;
        rd_idx_d    = '0;
        state_d     = PLAY;
      end
      PLAY: begin
        // rd_idx_q is the sample currently on fft_x; fetch the next one
        if (rd_idx_q == IDX_MAX) begin
          state_d = WAIT;
        end else begin
          rd_en       = 1'b1;
          rd_addr_idx = rd_idx_q + IDX_ONE;
          rd_idx_d    = rd_idx_q + IDX_ONE;
        end
      end
      WAIT: begin
        if (fft_done) begin
          bank_release = 1'b1;
          rd_bank_d    = ~rd_bank_q;
          rd_clr       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      bank_full_q <= 2'b00;
      frame_err_q <= 1'b0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      bank_full_q <= bank_full_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  // The RAM output register is the fft_x register
  fft_frame_ram #(
    .AW (LOG2N + 1),
    .W  (W)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr ({wr_bank_q, wr_idx_q}),
    .wdata (s_data),
    .re    (rd_en),
    .rclr  (rd_clr | ~rst),
    .raddr ({rd_bank_q, rd_addr_idx}),
    .rdata (fft_x)
  );

endmodule : fft_input_framer
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_framer
// Description : Directed self-checking bench for fft_input_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_framer;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        fft_start;
  logic [63:0] fft_x;
  logic        fft_done;
  logic        frame_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Cycle counter, observation state and done scheduling
  int cyc = 0;
  logic [63:0] got[$];
  int play_left       = 0;
  int start_cnt       = 0;
  int start_cyc       = -1;
  int err_cnt         = 0;
  int last_done_cyc   = -1;
  int last_sample_cyc = -1;
  int auto_dly        = 0;
  int auto_done_cyc   = -1;
  int manual_done_cyc = -1;

  fft_input_framer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .fft_start (fft_start),
    .fft_x     (fft_x),
    .fft_done  (fft_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        play_left = 0;
      end else begin
        if (play_left > 0) begin
          got.push_back(fft_x);
          play_left--;
          if (play_left == 0) begin
            last_sample_cyc = cyc;
            if (auto_dly > 0) auto_done_cyc = cyc + auto_dly;
          end
        end
        if (fft_start === 1'b1) begin
          start_cnt++;
          start_cyc = cyc;
          play_left = N;
        end
      end
      if (frame_err === 1'b1) err_cnt++;
      if (fft_done === 1'b1) last_done_cyc = cyc;
    end
  end

  // fft_done driver
  initial begin
    fft_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fft_done = (cyc == manual_done_cyc) || (cyc == auto_done_cyc);
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] samp(input logic [31:0] base, input int k, input bit plain);
    logic [31:0] v;
    v = base + 32'(k);
    if (plain) return 64'(k);
    return {v, ~v};
  endfunction

  function automatic int frame_mis(input int gb, input logic [31:0] base, input bit plain);
    int m;
    m = 0;
    if (got.size() < gb + N) return N;
    for (int k = 0; k < N; k++) begin
      if (got[gb + k] !== samp(base, k, plain)) m++;
    end
    return m;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send len beats; returns cycle of first/last transfer and first stall
  task automatic send_frame(input logic [31:0] base, input int len, input int last_at,
                            input bit plain, output int first_cyc, output int last_cyc,
                            output int first_stall);
    int guard;
    first_cyc   = -1;
    last_cyc    = -1;
    first_stall = -1;
    for (int k = 0; k < len; k++) begin
      s_valid = 1'b1;
      s_data  = samp(base, k, plain);
      s_last  = (k == last_at);
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 2000) begin
        if (first_stall < 0) first_stall = cyc;
        step(1);
        guard++;
      end
      if (guard >= 2000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: beat %0d never accepted, got=stall required=accept", k);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      if (k == 0) first_cyc = cyc;
      last_cyc = cyc;
      step(1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_play_done(input int target, output bit ok);
    int g;
    g = 0;
    while (!(start_cnt >= target && busy === 1'b0 && play_left == 0) && g < 3000) begin
      step(1);
      g++;
    end
    ok = (g < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    step(3);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got=%b required=0", s_ready); end
    total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL rst_fft_start: got=%b required=0", fft_start); end
    total++; if (fft_x !== 64'd0) begin bad++; $display("FAIL rst_fft_x: got=%h required=0", fft_x); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got=%b required=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b required=0", busy); end
    rst = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got=%b required=1", s_ready); end
    step(1);
  endtask

  task automatic test_single_frame();
    int f, l, st, gb, s0, e0;
    bit ok;
    auto_dly = 10; gb = got.size(); s0 = start_cnt; e0 = err_cnt;
    send_frame(32'h0, N, N - 1, 1'b1, f, l, st);
    wait_play_done(s0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got=busy required=idle"); end
    total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL single_starts: got=%0d required=%0d", start_cnt - s0, 1); end
    total++; if (start_cyc !== l + 2) begin bad++; $display("FAIL single_start_lat: got=%0d required=%0d", start_cyc, l + 2); end
    total++; if (frame_mis(gb, 32'h0, 1'b1) !== 0) begin bad++; $display("FAIL single_samples: got=%0d wrong required=0 wrong", frame_mis(gb, 32'h0, 1'b1)); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL single_frame_err: got=%0d pulses required=0", err_cnt - e0); end
    total++; if (last_done_cyc !== l + 2 + N + 10) begin bad++; $display("FAIL single_done_cyc: got=%0d required=%0d", last_done_cyc, l + 2 + N + 10); end
    total++; if (cyc !== last_done_cyc + 1) begin bad++; $display("FAIL single_release: got=%0d required=%0d", cyc, last_done_cyc + 1); end
    total++; if (fft_x !== 64'd0) begin bad++; $display("FAIL single_fft_x_clear: got=%h required=0", fft_x); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready_after: got=%b required=1", s_ready); end
  endtask

  task automatic test_back_to_back();
    int fa, la, sa, fb, lb, sb, fc, lc, sc, gb, s0, e0;
    bit ok;
    auto_dly = 300; gb = got.size(); s0 = start_cnt; e0 = err_cnt;
    send_frame(32'h1000, N, N - 1, 1'b0, fa, la, sa);
    send_frame(32'h2000, N, N - 1, 1'b0, fb, lb, sb);
    send_frame(32'h3000, N, N - 1, 1'b0, fc, lc, sc);
    total++; if (fb !== la + 1 || sb !== -1) begin bad++; $display("FAIL b2b_second_frame: got first=%0d stall=%0d required first=%0d stall=-1", fb, sb, la + 1); end
    total++; if (sc !== lb + 1) begin bad++; $display("FAIL b2b_ready_drop: got=%0d required=%0d", sc, lb + 1); end
    total++; if (fc !== la + 559) begin bad++; $display("FAIL b2b_ready_rise: got=%0d required=%0d", fc, la + 559); end
    wait_play_done(s0 + 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got=busy required=idle"); end
    total++; if (start_cnt !== s0 + 3) begin bad++; $display("FAIL b2b_starts: got=%0d required=3", start_cnt - s0); end
    total++; if (frame_mis(gb, 32'h1000, 1'b0) + frame_mis(gb + N, 32'h2000, 1'b0) + frame_mis(gb + 2 * N, 32'h3000, 1'b0) !== 0) begin
      bad++; $display("FAIL b2b_samples: got=%0d wrong required=0 wrong",
                      frame_mis(gb, 32'h1000, 1'b0) + frame_mis(gb + N, 32'h2000, 1'b0) + frame_mis(gb + 2 * N, 32'h3000, 1'b0));
    end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL b2b_frame_err: got=%0d required=0", err_cnt - e0); end
  endtask

  task automatic test_early_last();
    int f, l, st, gb, s0, e0;
    bit ok;
    auto_dly = 10; s0 = start_cnt; e0 = err_cnt;
    send_frame(32'h4000, 100, 99, 1'b0, f, l, st);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL early_err_pulse: got=%b required=1", frame_err); end
    step(1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL early_err_width: got=%b required=0", frame_err); end
    step(10);
    total++; if (start_cnt !== s0 || busy !== 1'b0) begin bad++; $display("FAIL early_no_start: got starts=%0d busy=%b required 0/0", start_cnt - s0, busy); end
    gb = got.size();
    send_frame(32'h5000, N, N - 1, 1'b0, f, l, st);
    wait_play_done(s0 + 1, ok);
    total++; if (!ok || start_cyc !== l + 2) begin bad++; $display("FAIL early_next_start: got=%0d required=%0d", start_cyc, l + 2); end
    total++; if (frame_mis(gb, 32'h5000, 1'b0) !== 0) begin bad++; $display("FAIL early_next_samples: got=%0d wrong required=0", frame_mis(gb, 32'h5000, 1'b0)); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL early_err_count: got=%0d required=1", err_cnt - e0); end
  endtask

  task automatic test_missing_last();
    int f, l, st, gb, s0, e0;
    bit ok;
    auto_dly = 10; gb = got.size(); s0 = start_cnt; e0 = err_cnt;
    send_frame(32'h6000, N, -1, 1'b0, f, l, st);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL missing_err_pulse: got=%b required=1", frame_err); end
    wait_play_done(s0 + 1, ok);
    total++; if (!ok || start_cnt !== s0 + 1) begin bad++; $display("FAIL missing_start: got=%0d required=1", start_cnt - s0); end
    total++; if (frame_mis(gb, 32'h6000, 1'b0) !== 0) begin bad++; $display("FAIL missing_samples: got=%0d wrong required=0", frame_mis(gb, 32'h6000, 1'b0)); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL missing_err_count: got=%0d required=1", err_cnt - e0); end
  endtask

  task automatic test_spurious_done();
    int f, l, st, gb, s0, g;
    bit ok;
    auto_dly = 10; gb = got.size(); s0 = start_cnt;
    send_frame(32'h7000, N, N - 1, 1'b0, f, l, st);
    manual_done_cyc = l + 2 + 1 + 50;
    g = 0;
    while (got.size() < gb + N && g < 1000) begin step(1); g++; end
    step(4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL spurious_hold: got busy=%b required=1", busy); end
    wait_play_done(s0 + 1, ok);
    total++; if (!ok || last_done_cyc !== last_sample_cyc + 10) begin bad++; $display("FAIL spurious_release: got=%0d required=%0d", last_done_cyc, last_sample_cyc + 10); end
    total++; if (frame_mis(gb, 32'h7000, 1'b0) !== 0) begin bad++; $display("FAIL spurious_samples: got=%0d wrong required=0", frame_mis(gb, 32'h7000, 1'b0)); end
    step(5);
    total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL spurious_starts: got=%0d required=1", start_cnt - s0); end
  endtask

  task automatic test_reset_mid_play();
    int f, l, st, gb, s0, e0;
    bit ok;
    auto_dly = 0; s0 = start_cnt; e0 = err_cnt;
    send_frame(32'h8000, N, N - 1, 1'b0, f, l, st);
    while (cyc < l + 43) step(1);
    total++; if (fft_x !== samp(32'h8000, 40, 1'b0)) begin bad++; $display("FAIL rmid_sample40: got=%h required=%h", fft_x, samp(32'h8000, 40, 1'b0)); end
    rst = 1'b0;
    step(1);
    total++; if ({fft_start, frame_err, busy, s_ready} !== 4'b0000 || fft_x !== 64'd0) begin
      bad++; $display("FAIL rmid_outputs: got start=%b err=%b busy=%b ready=%b x=%h required all 0",
                      fft_start, frame_err, busy, s_ready, fft_x);
    end
    step(1);
    rst = 1'b1;
    step(20);
    total++; if (start_cnt !== s0 + 1 || busy !== 1'b0) begin bad++; $display("FAIL rmid_no_restart: got starts=%0d busy=%b required 1/0", start_cnt - s0, busy); end
    auto_dly = 10; gb = got.size();
    send_frame(32'h9000, N, N - 1, 1'b0, f, l, st);
    wait_play_done(s0 + 2, ok);
    total++; if (!ok || start_cyc !== l + 2) begin bad++; $display("FAIL rmid_new_start: got=%0d required=%0d", start_cyc, l + 2); end
    total++; if (frame_mis(gb, 32'h9000, 1'b0) !== 0) begin bad++; $display("FAIL rmid_new_samples: got=%0d wrong required=0", frame_mis(gb, 32'h9000, 1'b0)); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL rmid_frame_err: got=%0d required=0", err_cnt - e0); end
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_spurious_done();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fft_input_framer
`default_nettype wire
